// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: forwarding-select encodings and per-stage destination shadows.
// Pure declarations; no latency or flow-control behaviour of its own.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  // Producer view of a stage: enough to decide whether it can feed a consumer.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  regwrite;
  } stage_shadow_t;

  // EX additionally tracks loads, which cannot forward until they reach MEM.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  regwrite;
    logic                  memread;
  } ex_shadow_t;

  function automatic logic is_fwd_src(stage_shadow_t s);
    return s.valid & s.regwrite & (s.dst != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Operand forwarding select: picks the youngest in-flight producer of one source register.
// Latency: combinational. Backpressure: none; the caller gates use_op on stall.
module fwd_sel_calc
  import cpu_pkg::*;
(
  input  logic                  use_op,
  input  logic [REG_ADDR_W-1:0] op,
  input  stage_shadow_t         ex_sh,
  input  stage_shadow_t         mem_sh,
  output logic [1:0]            sel
);

  // The EX entry is the younger producer, so it takes priority over MEM.
  always_comb begin
    sel = FWD_REGFILE;
    if (use_op) begin
      if (is_fwd_src(ex_sh) && (ex_sh.dst == op)) begin
        sel = FWD_MEM;
      end else if (is_fwd_src(mem_sh) && (mem_sh.dst == op)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/stall/flush control for the 5-stage pipe; selects registered at the ID->EX edge.
// Latency: selects valid the cycle the consumer is in EX; stall/flush are same-cycle combinational.
// Backpressure: a load-use hazard stalls PC and IF/ID for one cycle and bubbles ID/EX.
module fwd_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int FWD_SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  branch_taken,
  output logic [FWD_SEL_W-1:0]  fwd_a_sel,
  output logic [FWD_SEL_W-1:0]  fwd_b_sel,
  output logic                  stall,
  output logic                  flush_ifid
);

  // No WB shadow is kept: the register file is write-first, so WB never needs forwarding.
  ex_shadow_t     ex_q;
  stage_shadow_t  mem_q;
  stage_shadow_t  ex_view;
  logic [1:0]     a_sel;
  logic [1:0]     b_sel;
  logic           load_use;
  logic [FWD_SEL_W-1:0] a_q;
  logic [FWD_SEL_W-1:0] b_q;

  assign ex_view = '{valid: ex_q.valid, dst: ex_q.dst, regwrite: ex_q.regwrite};

  assign load_use = id_valid & ex_q.valid & ex_q.memread & (ex_q.dst != '0) &
                    ((id_use_rs & (id_rs == ex_q.dst)) |
                     (id_use_rt & (id_rt == ex_q.dst)));

  assign stall      = ~reset & load_use;
  assign flush_ifid = ~reset & branch_taken & id_valid & ~stall;

  // A stalled or empty ID slot enters EX as a bubble, so its selects are forced to regfile.
  fwd_sel_calc u_sel_a (
    .use_op (id_valid & id_use_rs & ~stall),
    .op     (id_rs),
    .ex_sh  (ex_view),
    .mem_sh (mem_q),
    .sel    (a_sel)
  );

  fwd_sel_calc u_sel_b (
    .use_op (id_valid & id_use_rt & ~stall),
    .op     (id_rt),
    .ex_sh  (ex_view),
    .mem_sh (mem_q),
    .sel    (b_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      a_q   <= FWD_REGFILE;
      b_q   <= FWD_REGFILE;
    end else begin
      mem_q <= ex_view;
      a_q   <= a_sel;
      b_q   <= b_sel;
      if (stall) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{valid: id_valid, dst: id_dst, regwrite: id_regwrite, memread: id_memread};
      end
    end
  end

  assign fwd_a_sel = a_q;
  assign fwd_b_sel = b_q;

endmodule
